edge_meas_sched: RTL and testbench
==================================

EDGE_MEAS_SCHED -- requirements
Module: edge_meas_sched

Interface
REQ-001 The module SHALL have parameter NCH, default 4, meaning the number of input channels (fixed at 4; the channel index is 2 bits).
REQ-002 The module SHALL have parameter CNT_W, default 8, meaning the result counter width.
REQ-003 The module SHALL have parameter WIN_W, default 16, meaning the window length width.
REQ-004 The module SHALL have port clk  in  1  system clock, rising edge.
REQ-005 The module SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-006 The module SHALL have port sig_in  in  NCH  asynchronous pulse inputs, one per channel.
REQ-007 The module SHALL have port chan_en  in  NCH  channel enable mask, sampled on an accepted start.
REQ-008 The module SHALL have port win_len  in  WIN_W  measurement window in clk cycles, sampled on an accepted start.
REQ-009 The module SHALL have port start  in  1  single-cycle sweep request.
REQ-010 The module SHALL have port stop  in  1  synchronous abort.
REQ-011 The module SHALL have port res_ready  in  1  result consumer ready.
REQ-012 The module SHALL have port res_valid  out  1  result available.
REQ-013 The module SHALL have port res_chan  out  2  channel index of the result.
REQ-014 The module SHALL have port res_count  out  CNT_W  rising-edge count of the result.
REQ-015 The module SHALL have port res_sat  out  1  count saturated during the window.
REQ-016 The module SHALL have port busy  out  1  high whenever the state is not IDLE.

Function
REQ-017 Each sig_in bit SHALL pass through a free-running 2-flop synchronizer plus 1 history flop; edge_det[i] = sync[i] & ~hist[i].
REQ-018 The FSM SHALL have states IDLE, LOAD, MEASURE and REPORT.
REQ-019 In IDLE, start with chan_en != 0 SHALL latch chan_en and win_len, select the lowest enabled channel, and go to LOAD; start with chan_en == 0 SHALL be ignored.
REQ-020 start SHALL be ignored in any state other than IDLE.
REQ-021 LOAD SHALL last 1 cycle, clear the counter and sat flag, load the window timer with max(win_len, 1), and go to MEASURE.
REQ-022 MEASURE SHALL last exactly the loaded window cycle count; each cycle with edge_det[sel] = 1 SHALL increment the counter.
REQ-023 The counter SHALL saturate at 2^CNT_W-1 (255); an edge arriving at 255 SHALL set sat and leave the count at 255.
REQ-024 After the last MEASURE cycle (including its edge) the FSM SHALL enter REPORT with res_valid = 1 and res_chan, res_count and res_sat stable.
REQ-025 A transfer SHALL occur on a cycle with res_valid & res_ready; the outputs SHALL hold until the transfer.
REQ-026 On transfer, if a higher-index latched-enabled channel exists, the FSM SHALL select the next such channel and go to LOAD; otherwise it SHALL go to IDLE.
REQ-027 Channels SHALL be visited in ascending order, once per sweep, with no wrap-around.
REQ-028 stop SHALL force IDLE on the next edge from any state and discard the in-flight or pending result; res_valid SHALL be 0 from that cycle.
REQ-029 stop SHALL take priority over start, over a transfer and over window completion in the same cycle.
REQ-030 Changes to chan_en and win_len during a sweep SHALL have no effect.
REQ-031 The edge history SHALL be unaffected by FSM state, so a level already high at LOAD SHALL NOT count as an edge.

Reset
REQ-032 While reset = 0: state SHALL be IDLE, all synchronizer/history flops 0, counter 0, sat 0, timer 0, latched mask 0, res_valid 0, res_chan 0, res_count 0, res_sat 0, busy 0.
REQ-033 Reset assertion mid-sweep SHALL abort immediately with no result delivered.
REQ-034 After reset release the first sweep SHALL behave identically to any later sweep.

Verification
REQ-035 chan_en=0101, win_len=100, res_ready=1, 3 pulses on ch0 and 7 on ch2 inside the windows -> results (0,3,sat=0) then (2,7,sat=0); busy drops after the second transfer.
REQ-036 chan_en=0001, win_len=1000, 300 pulses on ch0 -> res_count=255, res_sat=1.
REQ-037 res_ready held at 0 for 20 cycles in REPORT -> res_valid and data stable for 20 cycles; the next channel starts only after the transfer.
REQ-038 stop asserted mid-MEASURE of ch1 with chan_en=1110 -> IDLE next cycle, res_valid never asserted, busy=0.
REQ-039 start with chan_en=0000 -> stays IDLE; win_len=0 with one pulse aligned to MEASURE -> 1-cycle window, res_count=1.
REQ-040 reset pulled low in REPORT -> all outputs 0 immediately; a new start then produces a correct result.

Source files
------------

// File: rtl/edge_meas_sched.sv
// edge_meas_sched
//   Sweeps the enabled channels in ascending order. For each channel it counts
//   the rising edges seen on that channel's synchronized input during a fixed
//   window. It then presents the count through a valid/ready result port.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   sig_in     asynchronous pulse inputs, one per channel
//   chan_en    channel enable mask, captured on an accepted start
//   win_len    window length in clk cycles, captured on an accepted start
//   start      single-cycle sweep request (honoured only when idle)
//   stop       synchronous abort, highest priority
//   res_ready  result consumer ready
//   res_valid  result available
//   res_chan   channel index of the result
//   res_count  rising-edge count of the result (saturating)
//   res_sat    count saturated during the window
//   busy       high whenever a sweep is in progress
module edge_meas_sched #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   sig_in,
  input  logic [NCH-1:0]   chan_en,
  input  logic [WIN_W-1:0] win_len,
  input  logic             start,
  input  logic             stop,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [1:0]       res_chan,
  output logic [CNT_W-1:0] res_count,
  output logic             res_sat,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LOAD, MEASURE, REPORT} state_t;

  state_t           state_q, state_d;
  logic [NCH-1:0]   sync1_q, sync1_d;
  logic [NCH-1:0]   sync2_q, sync2_d;
  logic [NCH-1:0]   hist_q, hist_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIN_W-1:0] timer_q, timer_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic [NCH-1:0]   edge_det;
  logic [2:0]       nxt;

  // Lowest set bit of m whose index is >= from; result is {found, index}.
  function automatic logic [2:0] first_set(input logic [NCH-1:0] m,
                                           input logic [2:0] from);
    logic [2:0] r;
    r = 3'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i] && (i >= int'(from))) begin
        r = {1'b1, 2'(i)};
      end
    end
    return r;
  endfunction

  // The synchronizer and history run freely, independent of the FSM, so a
  // level that is already high when a window opens is never counted.
  assign edge_det = sync2_q & ~hist_q;

  always_comb begin
    state_d = state_q;
    sync1_d = sig_in;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    mask_d  = mask_q;
    win_d   = win_q;
    timer_d = timer_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    nxt     = 3'd0;

    case (state_q)
      IDLE: begin
        if (start && (chan_en != '0)) begin
          nxt     = first_set(chan_en, 3'd0);
          mask_d  = chan_en;
          win_d   = win_len;
          sel_d   = nxt[1:0];
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        sat_d   = 1'b0;
        // A zero length still gives a one-cycle window.
        timer_d = (win_q == '0) ? WIN_W'(1) : win_q;
        state_d = MEASURE;
      end
      MEASURE: begin
        if (edge_det[sel_q]) begin
          if (cnt_q == {CNT_W{1'b1}}) begin
            sat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        timer_d = timer_q - WIN_W'(1);
        if (timer_q <= WIN_W'(1)) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) begin
          nxt = first_set(mask_q, {1'b0, sel_q} + 3'd1);
          if (nxt[2]) begin
            sel_d   = nxt[1:0];
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // stop overrides start, a transfer and window completion alike.
    if (stop) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
      mask_q  <= '0;
      win_q   <= '0;
      timer_q <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      mask_q  <= mask_d;
      win_q   <= win_d;
      timer_q <= timer_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // A pending result is withdrawn in the same cycle that stop is raised.
  assign res_valid = (state_q == REPORT) && !stop;
  assign res_chan  = sel_q;
  assign res_count = cnt_q;
  assign res_sat   = sat_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_edge_meas_sched.sv
// tb_edge_meas_sched
//   Directed bench for edge_meas_sched: a linear sequence of sweeps with
//   hand-computed counts, window latencies and handshake behaviour.
module tb_edge_meas_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  sig_in;
  logic [3:0]  chan_en;
  logic [15:0] win_len;
  logic        start;
  logic        stop;
  logic        res_ready;
  logic        res_valid;
  logic [1:0]  res_chan;
  logic [7:0]  res_count;
  logic        res_sat;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  edge_meas_sched #(.NCH(4), .CNT_W(8), .WIN_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .sig_in    (sig_in),
    .chan_en   (chan_en),
    .win_len   (win_len),
    .start     (start),
    .stop      (stop),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_chan  (res_chan),
    .res_count (res_count),
    .res_sat   (res_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pulse = one cycle high followed by one cycle low.
  task automatic pulses(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in[ch] = 1'b1;
      tick();
      sig_in[ch] = 1'b0;
      tick();
    end
  endtask

  task automatic wait_valid(input int lim);
    int n;
    n = 0;
    while (!res_valid && n < lim) begin
      tick();
      n++;
    end
    if (!res_valid) chk("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_start(input logic [3:0] en, input logic [15:0] wl);
    chan_en = en;
    win_len = wl;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    chan_en = 4'b1111;  // later changes must not matter
    win_len = 16'd3;
  endtask

  initial begin
    int c0;
    logic seen;
    reset = 1'b0; sig_in = '0; chan_en = '0; win_len = '0;
    start = 1'b0; stop = 1'b0; res_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_chan",  res_chan,  2'd0);
    chk("rst_count", res_count, 8'd0);
    chk("rst_sat",   res_sat,   1'b0);
    chk("rst_busy",  busy,      1'b0);
    reset = 1'b1;
    tick();

    // Two-channel sweep, ch0 then ch2, window 100.
    c0 = cyc;
    do_start(4'b0101, 16'd100);
    chk("s1_busy", busy, 1'b1);
    pulses(0, 3);
    chk("s1_meas_valid", res_valid, 1'b0);
    wait_valid(200);
    chk("s1_lat0",   cyc - c0, 102);
    chk("s1_chan0",  res_chan, 2'd0);
    chk("s1_count0", res_count, 8'd3);
    chk("s1_sat0",   res_sat, 1'b0);
    tick();
    pulses(2, 7);
    wait_valid(200);
    chk("s1_lat2",   cyc - c0, 204);
    chk("s1_chan2",  res_chan, 2'd2);
    chk("s1_count2", res_count, 8'd7);
    chk("s1_sat2",   res_sat, 1'b0);
    chk("s1_busy_rep", busy, 1'b1);
    tick();
    chk("s1_busy_end", busy, 1'b0);
    chk("s1_valid_end", res_valid, 1'b0);

    // Saturation: 300 pulses in a 1000-cycle window.
    do_start(4'b0001, 16'd1000);
    pulses(0, 300);
    wait_valid(1100);
    chk("sat_count", res_count, 8'd255);
    chk("sat_flag",  res_sat, 1'b1);
    tick();
    chk("sat_idle", busy, 1'b0);

    // Back-pressure: hold ready low for 20 cycles in REPORT.
    res_ready = 1'b0;
    c0 = cyc;
    do_start(4'b0011, 16'd10);
    pulses(0, 2);
    wait_valid(50);
    chk("bp_lat", cyc - c0, 12);
    for (int i = 0; i < 20; i++) begin
      chk("bp_hold_valid", res_valid, 1'b1);
      chk("bp_hold_chan",  res_chan, 2'd0);
      chk("bp_hold_count", res_count, 8'd2);
      tick();
    end
    res_ready = 1'b1;
    tick();
    chk("bp_after_xfer_valid", res_valid, 1'b0);
    chk("bp_after_xfer_busy",  busy, 1'b1);
    wait_valid(50);
    chk("bp_lat1",   cyc - c0, 44);
    chk("bp_chan1",  res_chan, 2'd1);
    chk("bp_count1", res_count, 8'd0);
    tick();
    chk("bp_idle", busy, 1'b0);

    // Abort mid-MEASURE of ch1.
    seen = 1'b0;
    do_start(4'b1110, 16'd50);
    for (int i = 0; i < 4; i++) begin
      seen = seen | res_valid;
      tick();
    end
    chk("stop_busy_before", busy, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy",  busy, 1'b0);
    chk("stop_valid", res_valid, 1'b0);
    for (int i = 0; i < 60; i++) begin
      seen = seen | res_valid | busy;
      tick();
    end
    chk("stop_no_result", seen, 1'b0);

    // start with an empty mask is ignored; stop beats start.
    do_start(4'b0000, 16'd5);
    chk("empty_mask_idle", busy, 1'b0);
    stop = 1'b1;
    do_start(4'b0001, 16'd5);
    stop = 1'b0;
    chk("stop_over_start", busy, 1'b0);

    // Zero window length gives a one-cycle window; pulse aligned to it.
    sig_in[0] = 1'b1;
    do_start(4'b0001, 16'd0);
    sig_in[0] = 1'b0;
    tick();
    chk("w0_not_yet", res_valid, 1'b0);
    tick();
    chk("w0_valid", res_valid, 1'b1);
    chk("w0_count", res_count, 8'd1);
    tick();
    chk("w0_idle", busy, 1'b0);

    // A level already high at LOAD is not an edge; a later re-rise is.
    sig_in[0] = 1'b1;
    tick(); tick(); tick(); tick();
    do_start(4'b0001, 16'd10);
    tick(); tick(); tick();
    sig_in[0] = 1'b0;
    tick(); tick();
    sig_in[0] = 1'b1;
    wait_valid(30);
    chk("lvl_count", res_count, 8'd1);
    sig_in[0] = 1'b0;
    tick();

    // Reset while in REPORT, then a fresh sweep.
    res_ready = 1'b0;
    do_start(4'b0100, 16'd5);
    pulses(2, 2);
    wait_valid(30);
    chk("rr_pre_chan",  res_chan, 2'd2);
    chk("rr_pre_count", res_count, 8'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("rr_valid", res_valid, 1'b0);
    chk("rr_chan",  res_chan, 2'd0);
    chk("rr_count", res_count, 8'd0);
    chk("rr_sat",   res_sat, 1'b0);
    chk("rr_busy",  busy, 1'b0);
    tick();
    reset = 1'b1;
    res_ready = 1'b1;
    tick();
    c0 = cyc;
    do_start(4'b0010, 16'd20);
    pulses(1, 4);
    wait_valid(40);
    chk("rr_new_lat",   cyc - c0, 22);
    chk("rr_new_chan",  res_chan, 2'd1);
    chk("rr_new_count", res_count, 8'd4);
    chk("rr_new_sat",   res_sat, 1'b0);
    tick();
    chk("rr_new_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
